// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter and its datapath.
package alu_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_EQ  = 3'd1
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Single-cycle ALU: sum for add ops, operand equality always available.
module alu
  import alu_pkg::*;
#(
  parameter int Data_width = 32
) (
  input  logic [Data_width-1:0] op1_i,
  input  logic [Data_width-1:0] op2_i,
  input  logic [2:0]            ctrl_i,
  output logic [Data_width-1:0] result_o,
  output logic                  eq_o
);

  assign result_o = (ctrl_i == ALU_ADD) ? (op1_i + op2_i) : '0;
  assign eq_o     = (op1_i == op2_i);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters,
// one operation in flight, operands and results both registered.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_op1,
  input  logic [DATA_WIDTH-1:0] req0_op2,
  input  logic [2:0]            req0_ctrl,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp0_eq,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_op1,
  input  logic [DATA_WIDTH-1:0] req1_op2,
  input  logic [2:0]            req1_ctrl,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  rsp1_eq,
  output logic                  busy,
  output logic                  last_grant
);

  arb_state_e                           state_q;
  logic                                 prio_q;
  logic                                 last_grant_q;
  logic                                 id_q;
  logic [2:0]                           ctrl_q;
  logic [DATA_WIDTH-1:0]                op1_q;
  logic [DATA_WIDTH-1:0]                op2_q;
  logic [NUM_REQ-1:0]                   rsp_valid_q;
  logic [NUM_REQ-1:0]                   rsp_eq_q;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   rsp_data_q;

  logic                  grant0;
  logic                  grant1;
  logic [NUM_REQ-1:0]    rsp_ready_vec;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_eq;
  logic [DATA_WIDTH-1:0] res_data_d;
  logic                  res_eq_d;

  // A lone valid wins outright; a tie goes to the requester named by prio.
  assign grant0 = req0_valid && (!req1_valid || !prio_q);
  assign grant1 = req1_valid && (!req0_valid ||  prio_q);

  assign req0_ready    = (state_q == IDLE) && grant0;
  assign req1_ready    = (state_q == IDLE) && grant1;
  assign rsp_ready_vec = {rsp1_ready, rsp0_ready};

  alu #(
    .Data_width(DATA_WIDTH)
  ) u_alu (
    .op1_i   (op1_q),
    .op2_i   (op2_q),
    .ctrl_i  (ctrl_q),
    .result_o(alu_result),
    .eq_o    (alu_eq)
  );

  // Only the field defined by the op is forwarded; the other is forced to 0.
  always_comb begin
    res_data_d = '0;
    res_eq_d   = 1'b0;
    case (ctrl_q)
      ALU_ADD: res_data_d = alu_result;
      ALU_EQ:  res_eq_d   = alu_eq;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      last_grant_q <= 1'b0;
      id_q         <= 1'b0;
      ctrl_q       <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_eq_q     <= '0;
      rsp_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0_valid && req0_ready) begin
            id_q         <= 1'b0;
            ctrl_q       <= req0_ctrl;
            op1_q        <= req0_op1;
            op2_q        <= req0_op2;
            last_grant_q <= 1'b0;
            state_q      <= EXEC;
          end else if (req1_valid && req1_ready) begin
            id_q         <= 1'b1;
            ctrl_q       <= req1_ctrl;
            op1_q        <= req1_op1;
            op2_q        <= req1_op2;
            last_grant_q <= 1'b1;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q[id_q]  <= res_data_d;
          rsp_eq_q[id_q]    <= res_eq_d;
          rsp_valid_q[id_q] <= 1'b1;
          state_q           <= RESP;
        end
        RESP: begin
          // The owner of the finished op yields priority to the other side.
          if (rsp_ready_vec[id_q]) begin
            rsp_valid_q[id_q] <= 1'b0;
            prio_q            <= ~id_q;
            state_q           <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_data  = rsp_data_q[0];
  assign rsp1_data  = rsp_data_q[1];
  assign rsp0_eq    = rsp_eq_q[0];
  assign rsp1_eq    = rsp_eq_q[1];
  assign busy       = (state_q != IDLE);
  assign last_grant = last_grant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table of single operations plus
// hand-written arbitration, stall and reset sequences.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_eq;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_eq;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2, rsp0_data, rsp1_data;
  logic [2:0]  req0_ctrl, req1_ctrl;
  logic        busy, last_grant;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic        id;
    logic [2:0]  ctrl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] expData;
    logic        expEq;
  } vec_t;

  vec_t vecs[9];

  alu_arbiter #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_op1  (req0_op1),
    .req0_op2  (req0_op2),
    .req0_ctrl (req0_ctrl),
    .rsp0_valid(rsp0_valid),
    .rsp0_ready(rsp0_ready),
    .rsp0_data (rsp0_data),
    .rsp0_eq   (rsp0_eq),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_op1  (req1_op1),
    .req1_op2  (req1_op2),
    .req1_ctrl (req1_ctrl),
    .rsp1_valid(rsp1_valid),
    .rsp1_ready(rsp1_ready),
    .rsp1_data (rsp1_data),
    .rsp1_eq   (rsp1_eq),
    .busy      (busy),
    .last_grant(last_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic driveReq(input logic id, input logic v, input logic [2:0] c,
                          input logic [31:0] a, input logic [31:0] b);
    if (!id) begin
      req0_valid = v; req0_ctrl = c; req0_op1 = a; req0_op2 = b;
    end else begin
      req1_valid = v; req1_ctrl = c; req1_op1 = a; req1_op2 = b;
    end
  endtask

  task automatic setRspReady(input logic id, input logic v);
    if (!id) rsp0_ready = v;
    else     rsp1_ready = v;
  endtask

  function automatic logic reqReady(input logic id);
    return id ? req1_ready : req0_ready;
  endfunction

  function automatic logic rspValid(input logic id);
    return id ? rsp1_valid : rsp0_valid;
  endfunction

  function automatic logic [31:0] rspData(input logic id);
    return id ? rsp1_data : rsp0_data;
  endfunction

  function automatic logic rspEq(input logic id);
    return id ? rsp1_eq : rsp0_eq;
  endfunction

  task automatic checkReset(input string tag);
    checkFlag({tag, " busy"}, busy, 1'b0);
    checkFlag({tag, " last_grant"}, last_grant, 1'b0);
    checkFlag({tag, " rsp0_valid"}, rsp0_valid, 1'b0);
    checkFlag({tag, " rsp1_valid"}, rsp1_valid, 1'b0);
    checkOutput({tag, " rsp0_data"}, rsp0_data, 32'd0);
    checkOutput({tag, " rsp1_data"}, rsp1_data, 32'd0);
    checkFlag({tag, " rsp0_eq"}, rsp0_eq, 1'b0);
    checkFlag({tag, " rsp1_eq"}, rsp1_eq, 1'b0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkReset("reset");
    #3;
    rst_n = 1'b1;
    step();
  endtask

  // One isolated operation: accept, two cycles to response, then consume.
  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    driveReq(v.id, 1'b1, v.ctrl, v.op1, v.op2);
    #1;
    checkFlag({tag, " req_ready"}, reqReady(v.id), 1'b1);
    checkFlag({tag, " other req_ready"}, reqReady(~v.id), 1'b0);
    step();
    driveReq(v.id, 1'b0, 3'd0, 32'd0, 32'd0);
    checkFlag({tag, " busy"}, busy, 1'b1);
    checkFlag({tag, " last_grant"}, last_grant, v.id);
    checkFlag({tag, " rsp_valid early"}, rspValid(v.id), 1'b0);
    step();
    checkFlag({tag, " rsp_valid"}, rspValid(v.id), 1'b1);
    checkFlag({tag, " other rsp_valid"}, rspValid(~v.id), 1'b0);
    checkOutput({tag, " data"}, rspData(v.id), v.expData);
    checkFlag({tag, " eq"}, rspEq(v.id), v.expEq);
    setRspReady(v.id, 1'b1);
    step();
    setRspReady(v.id, 1'b0);
    checkFlag({tag, " rsp_valid cleared"}, rspValid(v.id), 1'b0);
    checkFlag({tag, " idle"}, busy, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 3'd0, 32'd5,          32'd7,          32'd12,   1'b0};
    vecs[1] = '{1'b0, 3'd0, 32'hFFFF_FFFF,  32'd1,          32'd0,    1'b0};
    vecs[2] = '{1'b1, 3'd5, 32'd123,        32'd123,        32'd0,    1'b0};
    vecs[3] = '{1'b0, 3'd1, 32'd3,          32'd4,          32'd0,    1'b0};
    vecs[4] = '{1'b1, 3'd1, 32'hDEAD_BEEF,  32'hDEAD_BEEF,  32'd0,    1'b1};
    vecs[5] = '{1'b1, 3'd0, 32'h8000_0000,  32'h8000_0000,  32'd0,    1'b0};
    vecs[6] = '{1'b0, 3'd7, 32'd1,          32'd2,          32'd0,    1'b0};
    vecs[7] = '{1'b0, 3'd2, 32'd5,          32'd5,          32'd0,    1'b0};
    vecs[8] = '{1'b1, 3'd0, 32'd1234,       32'd1111,       32'd2345, 1'b0};

    rst_n = 1'b0;
    driveReq(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    driveReq(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    #2;
    checkReset("power-on");
    checkFlag("power-on req0_ready", req0_ready, 1'b0);
    checkFlag("power-on req1_ready", req1_ready, 1'b0);
    #10;
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

    // Simultaneous requests right after reset: requester 0 first, then 1.
    doReset();
    driveReq(1'b0, 1'b1, 3'd1, 32'hA5, 32'hA5);
    driveReq(1'b1, 1'b1, 3'd0, 32'd1, 32'd2);
    #1;
    checkFlag("tie req0_ready", req0_ready, 1'b1);
    checkFlag("tie req1_ready", req1_ready, 1'b0);
    step();
    driveReq(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    checkFlag("tie last_grant 0", last_grant, 1'b0);
    checkFlag("tie req1 blocked in EXEC", req1_ready, 1'b0);
    step();
    checkFlag("tie rsp0_valid", rsp0_valid, 1'b1);
    checkFlag("tie rsp0_eq", rsp0_eq, 1'b1);
    checkOutput("tie rsp0_data", rsp0_data, 32'd0);
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    checkFlag("tie req1_ready after resp", req1_ready, 1'b1);
    step();
    driveReq(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    checkFlag("tie last_grant 1", last_grant, 1'b1);
    step();
    checkFlag("tie rsp1_valid", rsp1_valid, 1'b1);
    checkOutput("tie rsp1_data", rsp1_data, 32'd3);
    checkFlag("tie rsp1_eq", rsp1_eq, 1'b0);
    rsp1_ready = 1'b1;
    step();
    rsp1_ready = 1'b0;

    // Both requesters saturating with responses always accepted.
    doReset();
    driveReq(1'b0, 1'b1, 3'd0, 32'd10, 32'd20);
    driveReq(1'b1, 1'b1, 3'd1, 32'd9, 32'd9);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      logic exp;
      exp = k[0];
      checkFlag($sformatf("rr%0d granted ready", k), reqReady(exp), 1'b1);
      checkFlag($sformatf("rr%0d other ready", k), reqReady(~exp), 1'b0);
      step();
      checkFlag($sformatf("rr%0d last_grant", k), last_grant, exp);
      step();
      checkFlag($sformatf("rr%0d rsp_valid", k), rspValid(exp), 1'b1);
      checkOutput($sformatf("rr%0d data", k), rspData(exp), exp ? 32'd0 : 32'd30);
      checkFlag($sformatf("rr%0d eq", k), rspEq(exp), exp);
      step();
    end
    driveReq(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    driveReq(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    step();

    // Response stall on requester 0 while requester 1 waits.
    driveReq(1'b0, 1'b1, 3'd0, 32'd40, 32'd2);
    #1;
    checkFlag("stall req0_ready", req0_ready, 1'b1);
    step();
    driveReq(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    driveReq(1'b1, 1'b1, 3'd0, 32'd7, 32'd8);
    step();
    checkOutput("stall rsp0_data", rsp0_data, 32'd42);
    for (int c = 0; c < 10; c++) begin
      step();
      checkFlag($sformatf("stall%0d rsp0_valid", c), rsp0_valid, 1'b1);
      checkOutput($sformatf("stall%0d rsp0_data", c), rsp0_data, 32'd42);
      checkFlag($sformatf("stall%0d req1_ready", c), req1_ready, 1'b0);
    end
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    checkFlag("stall rsp0_valid cleared", rsp0_valid, 1'b0);
    checkFlag("stall req1_ready on idle", req1_ready, 1'b1);
    step();
    driveReq(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    checkFlag("stall last_grant", last_grant, 1'b1);
    step();
    checkFlag("stall rsp1_valid", rsp1_valid, 1'b1);
    checkOutput("stall rsp1_data", rsp1_data, 32'd15);
    rsp1_ready = 1'b1;
    step();
    rsp1_ready = 1'b0;

    // Reset during EXEC discards the operation.
    driveReq(1'b1, 1'b1, 3'd0, 32'd100, 32'd1);
    step();
    driveReq(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    checkFlag("midreset busy before", busy, 1'b1);
    checkFlag("midreset last_grant before", last_grant, 1'b1);
    rst_n = 1'b0;
    #1;
    checkReset("midreset");
    #3;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checkFlag($sformatf("postreset%0d rsp1_valid", c), rsp1_valid, 1'b0);
      checkFlag($sformatf("postreset%0d busy", c), busy, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
